hilo_unit: RTL



---
 rtl/hilo_unit_if.sv | 26 ++
 rtl/hilo_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hilo_unit_if.sv
// HI/LO unit request/result bundle: op request, multiplier product in, HI/LO and status out.
interface hilo_unit_if;
  logic        i_valid;
  logic [3:0]  i_op;
  logic [31:0] i_opr1;
  logic [31:0] i_opr2;
  logic [31:0] i_mult_hi;
  logic [31:0] i_mult_lo;
  logic        o_mult_unsigned;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_div_zero;

  // Pipeline side: issues ops, supplies operands/product, consumes HI/LO and status.
  modport master (
    output i_valid, i_op, i_opr1, i_opr2, i_mult_hi, i_mult_lo,
    input  o_mult_unsigned, o_hi, o_lo, o_busy, o_div_zero
  );

  // HI/LO unit side.
  modport slave (
    input  i_valid, i_op, i_opr1, i_opr2, i_mult_hi, i_mult_lo,
    output o_mult_unsigned, o_hi, o_lo, o_busy, o_div_zero
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: captures multiplier products, services MTHI/MTLO and runs a
// 32-step restoring divider for DIV/DIVU with a registered busy stall.
// Optional feature: define HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module hilo_unit #(
  parameter int unsigned DIV_ITERS = 32
) (
  input logic        clk,
  input logic        rst,
  hilo_unit_if.slave bus
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef HILO_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  localparam logic [4:0] LastIter = 5'(DIV_ITERS - 1);

  typedef enum logic [1:0] {StIdle, StDivRun, StDivFix} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;   // partial remainder (fits 32 bits between steps)
  logic [31:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient bits shift in
  logic [31:0] dsr_q, dsr_d;   // divisor magnitude
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        busy_q;
  logic        div_zero_q, div_zero_d;

  logic        accept;
  logic        is_signed_div;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [31:0] opr1_mag;
  logic [31:0] opr2_mag;
`ifdef HILO_MADD_EN
  logic [63:0] acc_sum;
  logic [63:0] acc_dif;
`endif

  assign accept = bus.i_valid & ~busy_q;

`ifdef HILO_MADD_EN
  assign bus.o_mult_unsigned = (bus.i_op == OpMultu) || (bus.i_op == OpMaddu);
  assign acc_sum = {hi_q, lo_q} + {bus.i_mult_hi, bus.i_mult_lo};
  assign acc_dif = {hi_q, lo_q} - {bus.i_mult_hi, bus.i_mult_lo};
`else
  assign bus.o_mult_unsigned = (bus.i_op == OpMultu);
`endif

  assign bus.o_hi       = hi_q;
  assign bus.o_lo       = lo_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_div_zero = div_zero_q;

  // Operand magnitudes for a divide request; DIVU passes operands through raw.
  always_comb begin
    is_signed_div = (bus.i_op == OpDiv);
    opr1_mag      = (is_signed_div && bus.i_opr1[31]) ? 32'(-bus.i_opr1) : bus.i_opr1;
    opr2_mag      = (is_signed_div && bus.i_opr2[31]) ? 32'(-bus.i_opr2) : bus.i_opr2;
  end

  // One restoring step: shift in next dividend bit, subtract, keep if no borrow.
  always_comb begin
    rem_shift = {rem_q, dvd_q[31]};
    diff      = rem_shift - {1'b0, dsr_q};
  end

  // Next-state and HI/LO update logic.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_zero_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.i_op)
            OpMult, OpMultu: begin
              hi_d = bus.i_mult_hi;
              lo_d = bus.i_mult_lo;
            end
            OpMthi: hi_d = bus.i_opr1;
            OpMtlo: lo_d = bus.i_opr1;
            OpDiv, OpDivu: begin
              if (bus.i_opr2 == 32'd0) begin
                div_zero_d = 1'b1;
              end else begin
                dvd_d   = opr1_mag;
                dsr_d   = opr2_mag;
                rem_d   = 32'd0;
                cnt_d   = 5'd0;
                q_neg_d = is_signed_div & (bus.i_opr1[31] ^ bus.i_opr2[31]);
                r_neg_d = is_signed_div & bus.i_opr1[31];
                state_d = StDivRun;
              end
            end
`ifdef HILO_MADD_EN
            OpMadd, OpMaddu: {hi_d, lo_d} = acc_sum;
            OpMsub, OpMsubu: {hi_d, lo_d} = acc_dif;
`endif
            default: ;
          endcase
        end
      end
      StDivRun: begin
        // diff[32] is the borrow; the remainder after a kept subtract is below the divisor.
        rem_d = diff[32] ? rem_shift[31:0] : diff[31:0];
        dvd_d = {dvd_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
          cnt_d   = 5'd0;
          state_d = StDivFix;
        end
      end
      StDivFix: begin
        lo_d    = q_neg_q ? 32'(-dvd_q) : dvd_q;
        hi_d    = r_neg_q ? 32'(-rem_q) : rem_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      cnt_q      <= 5'd0;
      rem_q      <= 32'd0;
      dvd_q      <= 32'd0;
      dsr_q      <= 32'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      busy_q     <= (state_d != StIdle);
      div_zero_q <= div_zero_d;
    end
  end

endmodule
